// File: rtl/secuenciador_alineacion_if.sv
// secuenciador_alineacion_if: request side and word-memory side signals of the alignment sequencer.
interface secuenciador_alineacion_if;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport slave (
    input  req, addr, size, we, wdata, mem_ack, mem_rdata,
    output busy, done, err, rdata, mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );
  modport master (
    output req, addr, size, we, wdata, mem_ack, mem_rdata,
    input  busy, done, err, rdata, mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/secuenciador_alineacion.sv
// secuenciador_alineacion: splits byte/half/word accesses into one or two word-memory accesses.
// Define MISALIGN_TRAP_EN to reject non-naturally-aligned accesses with err instead of splitting.
module secuenciador_alineacion #(
  parameter int MAX_WAIT = 15
) (
  input logic clk,
  input logic reset,
  secuenciador_alineacion_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;
  localparam logic [7:0] W_LIM = 8'(MAX_WAIT - 1);
  state_t      r_state;
  logic [31:0] r_addr, r_wdata, r_lo, r_rdata, r_mem_addr, r_mem_wdata;
  logic [1:0]  r_size;
  logic        r_we, r_busy, r_done, r_err, r_mem_req, r_mem_we;
  logic [3:0]  r_mem_be;
  logic [7:0]  r_wait;
  logic        w_idle, w_we, w_trap, w_cross;
  logic [31:0] w_a, w_wd, w_m32, w_rd;
  logic [1:0]  w_sz, w_off;
  logic [3:0]  w_mask;
  logic [2:0]  w_nb;
  logic [7:0]  w_be;
  logic [63:0] w_wd64, w_cat;
  // In IDLE the request inputs drive the first access directly; afterwards the latched copy does.
  always_comb begin
    w_idle = r_state == IDLE;
    w_a = w_idle ? bus.addr : r_addr;
    w_sz = w_idle ? bus.size : r_size;
    w_we = w_idle ? bus.we : r_we;
    w_wd = w_idle ? bus.wdata : r_wdata;
    w_off = w_a[1:0];
    w_mask = w_sz == 2'd0 ? 4'b0001 : w_sz == 2'd1 ? 4'b0011 : 4'b1111;
    w_nb = w_sz == 2'd0 ? 3'd1 : w_sz == 2'd1 ? 3'd2 : 3'd4;
    w_m32 = w_sz == 2'd0 ? 32'h0000_00FF : w_sz == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    w_cross = ({1'b0, w_off} + w_nb) > 3'd4;
`ifdef MISALIGN_TRAP_EN
    w_trap = w_sz == 2'd3 || (w_sz == 2'd1 && w_off[0]) || (w_sz == 2'd2 && w_off != 2'd0);
`else
    w_trap = w_sz == 2'd3;
`endif
    // Low half feeds the first word, high half the second word of a split access.
    w_be = {4'b0000, w_mask} << w_off;
    w_wd64 = {32'h0, w_wd} << {w_off, 3'b000};
    w_cat = r_state == ACC2 ? {bus.mem_rdata, r_lo} : {32'h0, bus.mem_rdata};
    w_rd = 32'(w_cat >> {w_off, 3'b000}) & w_m32;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_size <= '0;
      r_we <= 1'b0;
      r_wdata <= '0;
      r_lo <= '0;
      r_rdata <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_addr <= '0;
      r_mem_we <= 1'b0;
      r_mem_be <= '0;
      r_mem_wdata <= '0;
      r_wait <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.req) begin
          r_addr <= bus.addr;
          r_size <= bus.size;
          r_we <= bus.we;
          r_wdata <= bus.wdata;
          r_busy <= 1'b1;
          r_wait <= '0;
          if (w_trap) begin
            r_state <= DONE;
            r_done <= 1'b1;
            r_err <= 1'b1;
          end else begin
            r_state <= ACC1;
            r_mem_req <= 1'b1;
            r_mem_addr <= {w_a[31:2], 2'b00};
            r_mem_we <= w_we;
            r_mem_be <= w_we ? w_be[3:0] : 4'hF;
            r_mem_wdata <= w_we ? w_wd64[31:0] : 32'h0;
          end
        end
        ACC1, ACC2: if (bus.mem_ack) begin
          r_wait <= '0;
          if (r_state == ACC1 && w_cross) begin
            r_state <= ACC2;
            r_lo <= bus.mem_rdata;
            r_mem_addr <= r_mem_addr + 32'd4;
            r_mem_be <= r_we ? w_be[7:4] : 4'hF;
            r_mem_wdata <= r_we ? w_wd64[63:32] : 32'h0;
          end else begin
            r_state <= DONE;
            r_mem_req <= 1'b0;
            r_done <= 1'b1;
            if (!r_we) r_rdata <= w_rd;
          end
        end else if (r_wait == W_LIM) begin
          r_state <= DONE;
          r_mem_req <= 1'b0;
          r_done <= 1'b1;
          r_err <= 1'b1;
          r_wait <= '0;
        end else begin
          r_wait <= r_wait + 8'd1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          r_err <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err = r_err;
  assign bus.rdata = r_rdata;
  assign bus.mem_req = r_mem_req;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_we = r_mem_we;
  assign bus.mem_be = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_secuenciador_alineacion.sv
// tb_secuenciador_alineacion: directed checks of alignment, splitting, timeout, illegal size and reset.
module tb_secuenciador_alineacion;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_rd;
  secuenciador_alineacion_if bus ();
  secuenciador_alineacion #(.MAX_WAIT(15)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end
  task automatic drive(input logic [31:0] a, input logic [1:0] s, input logic w, input logic [31:0] d, input logic ack, input logic [31:0] md);
    bus.req = 1'b1; bus.addr = a; bus.size = s; bus.we = w; bus.wdata = d; bus.mem_ack = ack; bus.mem_rdata = md;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    drive(32'h0000_0004, 2'd2, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL rst_done_err got %b%b exp 00", bus.done, bus.err); end
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req_we got %b%b exp 00", bus.mem_req, bus.mem_we); end
    n_cmp++; if (bus.mem_be !== 4'h0) begin n_bad++; $display("FAIL rst_mem_be got %b exp 0000", bus.mem_be); end
    n_cmp++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.rdata !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h %h %h exp 0 0 0", bus.mem_addr, bus.mem_wdata, bus.rdata); end
    reset = 1'b0; bus.req = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_byte_read;
    drive(32'h0000_000D, 2'd0, 1'b0, 32'h0, 1'b1, 32'hAABB_CCDD);
    @(negedge clk); bus.req = 1'b0;
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL byte_req_busy got %b%b exp 11", bus.mem_req, bus.busy); end
    n_cmp++; if (bus.mem_addr !== 32'h0000_000C) begin n_bad++; $display("FAIL byte_addr got %h exp 0000000c", bus.mem_addr); end
    n_cmp++; if (bus.mem_be !== 4'hF || bus.done !== 1'b0) begin n_bad++; $display("FAIL byte_be_done got %b %b exp 1111 0", bus.mem_be, bus.done); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL byte_done got d%b e%b r%b exp d1 e0 r0", bus.done, bus.err, bus.mem_req); end
    exp_rd = 32'h0000_00CC;
    n_cmp++; if (bus.rdata !== exp_rd) begin n_bad++; $display("FAIL byte_rdata got %h exp %h", bus.rdata, exp_rd); end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL byte_idle got b%b d%b exp b0 d0", bus.busy, bus.done); end
  endtask
  task automatic test_word_cross(input logic [31:0] a, input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] rd);
    drive(a, 2'd2, 1'b0, 32'h0, 1'b1, d1);
    @(negedge clk); bus.req = 1'b0;
`ifdef MISALIGN_TRAP_EN
    n_cmp++; if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL trap_%h got d%b e%b r%b exp d1 e1 r0", a, bus.done, bus.err, bus.mem_req); end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL trap_idle_%h got b%b r%b exp b0 r0", a, bus.busy, bus.mem_req); end
`else
    n_cmp++; if (bus.mem_addr !== a1 || bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL cross_acc1_%h got %h r%b exp %h r1", a, bus.mem_addr, bus.mem_req, a1); end
    @(negedge clk); bus.mem_rdata = d2;
    n_cmp++; if (bus.mem_addr !== a2 || bus.mem_req !== 1'b1 || bus.done !== 1'b0) begin n_bad++; $display("FAIL cross_acc2_%h got %h r%b d%b exp %h r1 d0", a, bus.mem_addr, bus.mem_req, bus.done, a2); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin n_bad++; $display("FAIL cross_done_%h got d%b e%b exp d1 e0", a, bus.done, bus.err); end
    exp_rd = rd;
    n_cmp++; if (bus.rdata !== exp_rd) begin n_bad++; $display("FAIL cross_rdata_%h got %h exp %h", a, bus.rdata, exp_rd); end
    @(negedge clk);
`endif
  endtask
  task automatic test_timeout;
    int n = 0;
    drive(32'h0000_0010, 2'd0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk); bus.req = 1'b0;
    while (bus.mem_req === 1'b1 && n < 40) begin n++; @(negedge clk); end
    n_cmp++; if (n != 15) begin n_bad++; $display("FAIL timeout_cycles got %0d exp 15", n); end
    n_cmp++; if (bus.done !== 1'b1 || bus.err !== 1'b1) begin n_bad++; $display("FAIL timeout_done got d%b e%b exp d1 e1", bus.done, bus.err); end
    n_cmp++; if (bus.rdata !== exp_rd) begin n_bad++; $display("FAIL timeout_rdata got %h exp %h", bus.rdata, exp_rd); end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL timeout_idle got %b exp 0", bus.busy); end
  endtask
  task automatic test_illegal;
    drive(32'h0000_0020, 2'd3, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
    @(negedge clk); bus.req = 1'b0;
    n_cmp++; if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.mem_req !== 1'b0 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL illegal got d%b e%b r%b b%b exp d1 e1 r0 b1", bus.done, bus.err, bus.mem_req, bus.busy); end
    n_cmp++; if (bus.rdata !== exp_rd) begin n_bad++; $display("FAIL illegal_rdata got %h exp %h", bus.rdata, exp_rd); end
    @(negedge clk);
  endtask
  task automatic test_busy_ignore;
    drive(32'h0000_0008, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk); bus.addr = 32'h0000_0100; bus.size = 2'd0;
    n_cmp++; if (bus.mem_addr !== 32'h0000_0008) begin n_bad++; $display("FAIL busy_addr1 got %h exp 00000008", bus.mem_addr); end
    @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    n_cmp++; if (bus.mem_addr !== 32'h0000_0008 || bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL busy_addr2 got %h r%b exp 00000008 r1", bus.mem_addr, bus.mem_req); end
    @(negedge clk); bus.req = 1'b0;
    exp_rd = 32'hCAFE_F00D;
    n_cmp++; if (bus.done !== 1'b1 || bus.rdata !== exp_rd) begin n_bad++; $display("FAIL busy_done got d%b %h exp d1 %h", bus.done, bus.rdata, exp_rd); end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL busy_idle got b%b r%b exp b0 r0", bus.busy, bus.mem_req); end
  endtask
  task automatic test_half_write;
    drive(32'h0000_0003, 2'd1, 1'b1, 32'h0000_BEEF, 1'b1, 32'h0);
    @(negedge clk); bus.req = 1'b0;
`ifdef MISALIGN_TRAP_EN
    n_cmp++; if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL hw_trap got d%b e%b r%b exp d1 e1 r0", bus.done, bus.err, bus.mem_req); end
    @(negedge clk);
`else
    n_cmp++; if (bus.mem_be !== 4'b1000 || bus.mem_wdata !== 32'hEF00_0000) begin n_bad++; $display("FAIL hw_acc1 got %b %h exp 1000 ef000000", bus.mem_be, bus.mem_wdata); end
    n_cmp++; if (bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL hw_acc1_addr got %h w%b exp 00000000 w1", bus.mem_addr, bus.mem_we); end
    @(negedge clk);
    n_cmp++; if (bus.mem_be !== 4'b0001 || bus.mem_wdata !== 32'h0000_00BE) begin n_bad++; $display("FAIL hw_acc2 got %b %h exp 0001 000000be", bus.mem_be, bus.mem_wdata); end
    n_cmp++; if (bus.mem_addr !== 32'h0000_0004) begin n_bad++; $display("FAIL hw_acc2_addr got %h exp 00000004", bus.mem_addr); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin n_bad++; $display("FAIL hw_done got d%b e%b exp d1 e0", bus.done, bus.err); end
    @(negedge clk);
`endif
  endtask
  task automatic test_reset_mid;
    logic [31:0] a = 32'h0000_0002, a2 = 32'h0000_0004;
    logic ack = 1'b1;
`ifdef MISALIGN_TRAP_EN
    a = 32'h0; a2 = 32'h0; ack = 1'b0;
`endif
    drive(a, 2'd2, 1'b0, 32'h0, ack, 32'h9999_9999);
    @(negedge clk); bus.req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.mem_addr !== a2 || bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL rm_pre got %h r%b exp %h r1", bus.mem_addr, bus.mem_req, a2); end
    reset = 1'b1; bus.mem_ack = 1'b0;
    @(negedge clk); reset = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL rm_ctl got b%b d%b e%b r%b exp 0000", bus.busy, bus.done, bus.err, bus.mem_req); end
    n_cmp++; if (bus.mem_addr !== 32'h0 || bus.mem_be !== 4'h0 || bus.rdata !== 32'h0) begin n_bad++; $display("FAIL rm_data got %h %b %h exp 0 0 0", bus.mem_addr, bus.mem_be, bus.rdata); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rm_nodone got d%b b%b exp d0 b0", bus.done, bus.busy); end
    drive(32'h0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    @(negedge clk); bus.req = 1'b0;
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL rm_accept got r%b %h exp r1 00000000", bus.mem_req, bus.mem_addr); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1 || bus.rdata !== 32'h0000_0078) begin n_bad++; $display("FAIL rm_done got d%b %h exp d1 00000078", bus.done, bus.rdata); end
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b1;
    bus.req = 1'b0; bus.addr = '0; bus.size = '0; bus.we = 1'b0; bus.wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    exp_rd = '0;
    @(negedge clk);
    test_reset;
    test_byte_read;
    test_word_cross(32'h0000_0001, 32'h0000_0000, 32'h0000_0004, 32'h4433_2211, 32'h8877_6655, 32'h5544_3322);
    test_word_cross(32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 32'h1122_3344, 32'h5566_7788, 32'h7788_1122);
    test_timeout;
    test_illegal;
    test_busy_ignore;
    test_half_write;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/secuenciador_alineacion.md
SECUENCIADOR_ALINEACION -- requirements
Module: secuenciador_alineacion

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, max cycles mem_req may wait for mem_ack before the access is aborted (range 1-255).
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-004 SHALL have ports: req  in  1, addr  in  32, size  in  2 (00 byte, 01 half, 10 word, 11 illegal), we  in  1, wdata  in  32 (right-justified).
REQ-005 SHALL have ports: busy  out  1, done  out  1 (one-cycle pulse), err  out  1 (valid with done), rdata  out  32 (right-justified, zero-extended).
REQ-006 SHALL have ports: mem_req  out  1, mem_addr  out  32, mem_we  out  1, mem_be  out  4, mem_wdata  out  32, mem_ack  in  1, mem_rdata  in  32.

Function
REQ-007 SHALL use little-endian lanes: byte at offset k = addr[1:0] maps to mem bits 8k+7:8k.
REQ-008 SHALL accept req only in IDLE; addr/size/we/wdata latched on the acceptance cycle T; req while busy ignored.
REQ-009 SHALL implement states IDLE, ACC1, ACC2, DONE; IDLE->ACC1 on accept, ACC1->ACC2 on mem_ack if access crosses a word boundary, else ACC1->DONE; ACC2->DONE on mem_ack; DONE->IDLE unconditionally.
REQ-010 SHALL treat an access as crossing when offset + nbytes > 4 (word at offset 1-3, half at offset 3).
REQ-011 SHALL drive mem_addr = {addr[31:2],2'b00} in ACC1 and that value + 4 (mod 2^32, 0xFFFFFFFC wraps to 0x00000000) in ACC2; mem_addr[1:0] always 0.
REQ-012 SHALL hold mem_req high with mem_addr/mem_we/mem_be/mem_wdata stable in ACC1/ACC2 until mem_ack sampled high; mem_req low in IDLE and DONE.
REQ-013 SHALL drive mem_be = (mask << offset)[3:0] in ACC1 and mask >> (4-offset) in ACC2, mask = 0001/0011/1111 for byte/half/word; mem_wdata shifted left 8*offset (ACC1) and right 8*(4-offset) (ACC2); mem_be = 1111 on reads.
REQ-014 SHALL assemble rdata from ACC1 lanes shifted right 8*offset, with ACC2 lanes filling upper bytes, masked to nbytes; rdata updated only at DONE and held until next DONE.
REQ-015 SHALL assert busy from T+1 through the DONE cycle inclusive; done and err high only in DONE.
REQ-016 SHALL count cycles in ACC1/ACC2 without mem_ack (counter reset per access); on reaching MAX_WAIT go to DONE with err=1, skipping any remaining access; rdata unchanged.
REQ-017 SHALL give latency: aligned access with immediate ack, done at T+2; crossing access with immediate acks, done at T+3.
REQ-018 SHALL complete size=11 without memory access: DONE at T+1, err=1.

Reset
REQ-019 SHALL, when reset sampled high, enter IDLE and force busy, done, err, mem_req, mem_we = 0, mem_be = 0000, mem_addr, mem_wdata, rdata = 0, wait counter = 0.
REQ-020 SHALL abort any in-flight access on reset without producing done; reset takes priority over req and mem_ack in the same cycle.

Configuration
REQ-021 SHALL, with macro MISALIGN_TRAP_EN defined, complete any non-naturally-aligned access (half with addr[0]=1, word with addr[1:0]!=0) at T+1 with done=1, err=1, no mem_req; ACC2 unreachable.
REQ-022 SHALL, without MISALIGN_TRAP_EN, split crossing accesses per REQ-009 to REQ-014 and raise err only for size=11 or timeout.

Verification
REQ-023 SHALL verify: byte read addr 0x0000000D, mem_rdata 0xAABBCCDD, ack immediate -> mem_addr 0x0000000C, rdata 0x000000CC, done at T+2, err 0.
REQ-024 SHALL verify: word read addr 0x00000001, mem_rdata 0x44332211 then 0x88776655 -> mem_addr 0x0 then 0x4, rdata 0x55443322, done at T+3 (macro undefined); done+err at T+1, no mem_req (macro defined).
REQ-025 SHALL verify: half write addr 0x00000003, wdata 0x0000BEEF -> ACC1 be 1000, mem_wdata 0xEF000000 at 0x0; ACC2 be 0001, mem_wdata 0x000000BE at 0x4.
REQ-026 SHALL verify: word read addr 0xFFFFFFFE -> mem_addr 0xFFFFFFFC then 0x00000000.
REQ-027 SHALL verify: mem_ack never asserted, MAX_WAIT=15 -> mem_req high exactly 15 cycles, then done=1, err=1, rdata unchanged.
REQ-028 SHALL verify: reset asserted in ACC2 -> next cycle IDLE, all outputs 0, no done pulse; new req accepted the cycle after reset deasserts.
